// File: rtl/l1_cache_responder_if.sv
// CPU, directory-memory and snoop signal bundle for l1_cache_responder.
//   slave  : the cache side (receives CPU requests, memory responses and snoops)
//   master : the requester/directory side (a CPU model plus memory/directory agent)
// Signal names keep the cache-relative _i/_o suffixes on both modports.
interface l1_cache_responder_if #(
  parameter int unsigned WIDTH = 32
) ();
  // CPU side
  logic             CPU_read_en_i;
  logic             CPU_write_en_i;
  logic [WIDTH-1:0] CPU_address_i;
  logic [WIDTH-1:0] CPU_write_data_i;
  logic             CPU_data_en_o;
  logic [WIDTH-1:0] CPU_read_data_o;
  // Directory request channel
  logic             mem_req_o;
  logic [1:0]       mem_cmd_o;
  logic [WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic             mem_ack_i;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             mem_shared_i;
  // Snoop channel
  logic             snoop_inv_i;
  logic [WIDTH-1:0] snoop_addr_i;
  logic             snoop_ack_o;
  logic             snoop_dirty_o;
  logic [WIDTH-1:0] snoop_data_o;

  modport slave (
    input  CPU_read_en_i, CPU_write_en_i, CPU_address_i, CPU_write_data_i,
    input  mem_ack_i, mem_rdata_i, mem_shared_i, snoop_inv_i, snoop_addr_i,
    output CPU_data_en_o, CPU_read_data_o, mem_req_o, mem_cmd_o, mem_addr_o, mem_wdata_o,
    output snoop_ack_o, snoop_dirty_o, snoop_data_o
  );

  modport master (
    output CPU_read_en_i, CPU_write_en_i, CPU_address_i, CPU_write_data_i,
    output mem_ack_i, mem_rdata_i, mem_shared_i, snoop_inv_i, snoop_addr_i,
    input  CPU_data_en_o, CPU_read_data_o, mem_req_o, mem_cmd_o, mem_addr_o, mem_wdata_o,
    input  snoop_ack_o, snoop_dirty_o, snoop_data_o
  );
endinterface

// File: rtl/l1_cache_responder.sv
// Direct-mapped, one-word-per-line L1 cache with MESI line states, serving one CPU and
// talking to a coherence directory.
//   sys_clk   : clock, rising edge
//   sys_rst_n : asynchronous active-low reset (all lines I, all outputs 0)
//   bus       : l1_cache_responder_if.slave
//               CPU load/store request levels and one-cycle completion pulse,
//               directory request channel (BusRd/BusRdX/BusUpgr/WriteBack + ack),
//               snoop invalidate channel (pulse in, ack pulse out with dirty data).
// Hits complete in IDLE with a pulse on the next cycle; misses and upgrades go through
// WB/FILL/UPGR and complete from RESP one cycle after the final ack.
module l1_cache_responder #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned INDEX_W = 4
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  l1_cache_responder_if.slave bus
);
  localparam int unsigned TagW  = WIDTH - INDEX_W - 2;
  localparam int unsigned WordW = WIDTH - 2;
  localparam int unsigned Lines = 2 ** INDEX_W;

  localparam logic [1:0] MesiI = 2'b00;
  localparam logic [1:0] MesiS = 2'b01;
  localparam logic [1:0] MesiE = 2'b10;
  localparam logic [1:0] MesiM = 2'b11;

  localparam logic [1:0] CmdBusRd     = 2'b00;
  localparam logic [1:0] CmdBusRdX    = 2'b01;
  localparam logic [1:0] CmdBusUpgr   = 2'b10;
  localparam logic [1:0] CmdWriteBack = 2'b11;

  typedef enum logic [2:0] {StIdle, StWb, StFill, StUpgr, StResp} state_e;

  state_e state_q, state_d;

  logic [TagW-1:0]  tag_q  [Lines];
  logic [TagW-1:0]  tag_d  [Lines];
  logic [WIDTH-1:0] data_q [Lines];
  logic [WIDTH-1:0] data_d [Lines];
  logic [1:0]       mesi_q [Lines];
  logic [1:0]       mesi_d [Lines];

  // Captured request (word address only; byte offset is irrelevant)
  logic             req_write_q, req_write_d;
  logic [WordW-1:0] req_word_q, req_word_d;
  logic [WIDTH-1:0] req_wdata_q, req_wdata_d;

  // Registered outputs so reset clears them immediately
  logic             data_en_q, data_en_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             mem_req_q, mem_req_d;
  logic [1:0]       mem_cmd_q, mem_cmd_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             snp_ack_q, snp_ack_d;
  logic             snp_dirty_q, snp_dirty_d;
  logic [WIDTH-1:0] snp_data_q, snp_data_d;

  logic [INDEX_W-1:0] cpu_idx, req_idx, snp_idx;
  logic [TagW-1:0]    cpu_tag, req_tag, snp_tag;
  logic               cpu_hit;
  logic               unused_offset_bits;

  assign cpu_idx = bus.CPU_address_i[INDEX_W+1:2];
  assign cpu_tag = bus.CPU_address_i[WIDTH-1:INDEX_W+2];
  assign req_idx = req_word_q[INDEX_W-1:0];
  assign req_tag = req_word_q[WordW-1:INDEX_W];
  assign snp_idx = bus.snoop_addr_i[INDEX_W+1:2];
  assign snp_tag = bus.snoop_addr_i[WIDTH-1:INDEX_W+2];
  assign cpu_hit = (mesi_q[cpu_idx] != MesiI) && (tag_q[cpu_idx] == cpu_tag);

  assign unused_offset_bits = ^{bus.CPU_address_i[1:0], bus.snoop_addr_i[1:0]};

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mesi_d      = mesi_q;
    req_write_d = req_write_q;
    req_word_d  = req_word_q;
    req_wdata_d = req_wdata_q;
    data_en_d   = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_cmd_d   = mem_cmd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    snp_ack_d   = 1'b0;
    snp_dirty_d = 1'b0;
    snp_data_d  = '0;

    unique case (state_q)
      StIdle: begin
        // The pulse cycle itself is not a sampling point; a request still held in the
        // following cycle counts as a new one.
        if (!data_en_q && (bus.CPU_read_en_i || bus.CPU_write_en_i)) begin
          req_write_d = bus.CPU_write_en_i;
          req_word_d  = bus.CPU_address_i[WIDTH-1:2];
          req_wdata_d = bus.CPU_write_data_i;
          if (cpu_hit) begin
            if (!bus.CPU_write_en_i) begin
              rdata_d   = data_q[cpu_idx];
              data_en_d = 1'b1;
            end else if (mesi_q[cpu_idx] == MesiS) begin
              state_d = StUpgr;
            end else begin
              data_d[cpu_idx] = bus.CPU_write_data_i;
              mesi_d[cpu_idx] = MesiM;
              rdata_d         = bus.CPU_write_data_i;
              data_en_d       = 1'b1;
            end
          end else if (mesi_q[cpu_idx] == MesiM) begin
            state_d = StWb;
          end else begin
            state_d = StFill;
          end
        end
      end

      StWb: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_cmd_d   = CmdWriteBack;
          mem_addr_d  = {tag_q[req_idx], req_idx, 2'b00};
          mem_wdata_d = data_q[req_idx];
        end else if (bus.mem_ack_i) begin
          mem_req_d       = 1'b0;
          mesi_d[req_idx] = MesiI;
          state_d         = StFill;
        end
      end

      StFill: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_cmd_d   = req_write_q ? CmdBusRdX : CmdBusRd;
          mem_addr_d  = {req_word_q, 2'b00};
          mem_wdata_d = '0;
        end else if (bus.mem_ack_i) begin
          mem_req_d      = 1'b0;
          tag_d[req_idx] = req_tag;
          if (req_write_q) begin
            data_d[req_idx] = req_wdata_q;
            mesi_d[req_idx] = MesiM;
            rdata_d         = req_wdata_q;
          end else begin
            data_d[req_idx] = bus.mem_rdata_i;
            mesi_d[req_idx] = bus.mem_shared_i ? MesiS : MesiE;
            rdata_d         = bus.mem_rdata_i;
          end
          data_en_d = 1'b1;
          state_d   = StResp;
        end
      end

      StUpgr: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_cmd_d   = CmdBusUpgr;
          mem_addr_d  = {req_word_q, 2'b00};
          mem_wdata_d = '0;
        end else if (bus.mem_ack_i) begin
          mem_req_d       = 1'b0;
          data_d[req_idx] = req_wdata_q;
          mesi_d[req_idx] = MesiM;
          rdata_d         = req_wdata_q;
          data_en_d       = 1'b1;
          state_d         = StResp;
        end
      end

      // Completion pulse is on the outputs during this cycle
      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    // Snoop looks at the line after any same-cycle hit update, so a coinciding store hit
    // is reported as dirty data and then invalidated.
    if (bus.snoop_inv_i) begin
      snp_ack_d = 1'b1;
      if ((mesi_d[snp_idx] != MesiI) && (tag_d[snp_idx] == snp_tag)) begin
        snp_dirty_d     = (mesi_d[snp_idx] == MesiM);
        snp_data_d      = data_d[snp_idx];
        mesi_d[snp_idx] = MesiI;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      tag_q       <= '{default: '0};
      data_q      <= '{default: '0};
      mesi_q      <= '{default: MesiI};
      req_write_q <= 1'b0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      data_en_q   <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_cmd_q   <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      snp_ack_q   <= 1'b0;
      snp_dirty_q <= 1'b0;
      snp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      mesi_q      <= mesi_d;
      req_write_q <= req_write_d;
      req_word_q  <= req_word_d;
      req_wdata_q <= req_wdata_d;
      data_en_q   <= data_en_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      snp_ack_q   <= snp_ack_d;
      snp_dirty_q <= snp_dirty_d;
      snp_data_q  <= snp_data_d;
    end
  end

  assign bus.CPU_data_en_o   = data_en_q;
  assign bus.CPU_read_data_o = rdata_q;
  assign bus.mem_req_o       = mem_req_q;
  assign bus.mem_cmd_o       = mem_cmd_q;
  assign bus.mem_addr_o      = mem_addr_q;
  assign bus.mem_wdata_o     = mem_wdata_q;
  assign bus.snoop_ack_o     = snp_ack_q;
  assign bus.snoop_dirty_o   = snp_dirty_q;
  assign bus.snoop_data_o    = snp_data_q;

endmodule
